// File: rtl/onewire_pkg.sv
// Shared 1-Wire frame constants, FSM state type and the serial Dallas CRC-8 step.
package onewire_pkg;

    localparam int DATA_W      = 56;
    localparam int CRC_W       = 8;
    localparam int BIT_TIMEOUT = 2048;
    localparam logic [CRC_W-1:0] POLY_R = 8'h8C;

    localparam int FRAME_W = DATA_W + CRC_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMO_W   = $clog2(BIT_TIMEOUT + 1);
    localparam int IDX_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    // One LSB-first step of the reflected CRC; shared by RX check and TX generation.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc_in,
                                                   input logic             bit_in);
        logic fb;
        fb = crc_in[0] ^ bit_in;
        crc8_step = (crc_in >> 1) ^ (fb ? POLY_R : '0);
    endfunction

endpackage

// File: rtl/onewire_crc8_serial.sv
// Bit-serial Dallas CRC-8 accumulator: clear has priority over en; result visible
// the cycle after each enabled bit. No flow control, one bit per enabled cycle.
module onewire_crc8_serial
    import onewire_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/onewire_rx_deframer.sv
// Assembles LSB-first slot bits into payload + CRC-8, flags CRC/abort/timeout errors;
// o_valid one cycle after the final CRC bit. No backpressure: outputs are a 1-cycle strobe.
module onewire_rx_deframer
    import onewire_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_frame_start,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_command,
    output logic              o_valid,
    output logic              o_error,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BIT_TIMEOUT - 1);

    state_t            st, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo;
    logic [DATA_W-1:0] shift;
    logic [CRC_W-1:0]  crc;
    logic              pend_start;

    logic in_frame;
    logic accept;
    logic start_now;
    logic done_ok;
    logic done_bad;

    assign in_frame = (st == DATA) || (st == CRC);

    always_comb begin
        nxt       = st;
        accept    = 1'b0;
        start_now = 1'b0;
        done_ok   = 1'b0;
        done_bad  = 1'b0;
        case (st)
            IDLE: begin
                if (i_frame_start) begin
                    nxt       = DATA;
                    start_now = 1'b1;
                end
            end
            DATA, CRC: begin
                // A new frame start aborts the current one; it is replayed from DONE.
                if (i_frame_start) begin
                    nxt      = DONE;
                    done_bad = 1'b1;
                end else if (i_bit_valid) begin
                    accept = 1'b1;
                    if (st == DATA && cnt == LAST_DATA) begin
                        nxt = CRC;
                    end else if (st == CRC && cnt == LAST_BIT) begin
                        nxt     = DONE;
                        done_ok = 1'b1;
                    end
                end else if (tmo == TMO_LAST) begin
                    nxt      = DONE;
                    done_bad = 1'b1;
                end
            end
            DONE: begin
                if (pend_start || i_frame_start) begin
                    nxt       = DATA;
                    start_now = 1'b1;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            tmo        <= '0;
            shift      <= '0;
            pend_start <= 1'b0;
        end else begin
            if (start_now) begin
                cnt   <= '0;
                tmo   <= '0;
                shift <= '0;
            end else if (accept) begin
                if (st == DATA) begin
                    shift[cnt[IDX_W-1:0]] <= i_bit;
                end
                cnt <= cnt + 1'b1;
                tmo <= '0;
            end else if (in_frame) begin
                tmo <= tmo + 1'b1;
            end

            if (st == DONE) begin
                pend_start <= 1'b0;
            end else if (in_frame && i_frame_start) begin
                pend_start <= 1'b1;
            end
        end
    end

    // Results load on entry to DONE so they are already stable while o_valid is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_command <= '0;
            o_error   <= 1'b0;
        end else if (done_ok) begin
            o_command <= shift;
            o_error   <= (crc8_step(crc, i_bit) != '0);
        end else if (done_bad) begin
            o_error <= 1'b1;
        end
    end

    onewire_crc8_serial u_crc (
        .clk      (clk),
        .reset    (reset),
        .clear    (i_frame_start || start_now),
        .en       (accept),
        .data_bit (i_bit),
        .crc      (crc)
    );

    assign o_valid = (st == DONE);
    assign o_busy  = in_frame;

endmodule

// File: tb/tb_onewire_rx_deframer.sv
// Directed bench for onewire_rx_deframer: stimulus pushes expected frame results,
// a negedge monitor pops and compares them whenever o_valid is seen.
module tb_onewire_rx_deframer;
    import onewire_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_frame_start;
    logic              i_bit_valid;
    logic              i_bit;
    logic [DATA_W-1:0] o_command;
    logic              o_valid;
    logic              o_error;
    logic              o_busy;

    always #5 clk = ~clk;

    onewire_rx_deframer dut (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (i_frame_start),
        .i_bit_valid   (i_bit_valid),
        .i_bit         (i_bit),
        .o_command     (o_command),
        .o_valid       (o_valid),
        .o_error       (o_error),
        .o_busy        (o_busy)
    );

    typedef struct packed {
        logic [DATA_W-1:0] cmd;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] last_cmd;

    localparam logic [DATA_W-1:0] P_ZERO = '0;
    localparam logic [DATA_W-1:0] P_AA55 = 56'hAA55AA55AA55AA;
    localparam logic [DATA_W-1:0] P_SEQ  = 56'h0123456789ABCD;
    localparam logic [DATA_W-1:0] P_BEEF = 56'hDEADBEEF123456;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference Dallas CRC-8 over the payload, LSB first (8'h24 for P_AA55).
    function automatic logic [7:0] ref_crc(input logic [DATA_W-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < DATA_W; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got o_valid=1 cmd=%0h err=%0b, required no strobe",
                             o_command, o_error);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_command", 64'(o_command), 64'(mon_e.cmd));
                    check("frame_error", 64'(o_error), 64'(mon_e.err));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_frame_start = 1'b1;
        tick(1);
        i_frame_start = 1'b0;
        tick(1);
    endtask

    task automatic send_bits(input logic [63:0] f, input int n, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            i_bit       = f[i];
            i_bit_valid = 1'b1;
            tick(1);
            i_bit_valid = 1'b0;
            if (chk_lat && i == n - 1) check("valid_latency", 64'(o_valid), 64'd1);
            if (i == 20) check("busy_mid_frame", 64'(o_busy), 64'd1);
            tick(2);
        end
    endtask

    task automatic good_or_bad_frame(input logic [DATA_W-1:0] d, input logic [7:0] c,
                                     input logic exp_err);
        exp_q.push_back('{cmd: d, err: exp_err});
        last_cmd = d;
        start_frame();
        send_bits({c, d}, FRAME_W, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        i_frame_start = 1'b0;
        i_bit_valid   = 1'b0;
        i_bit         = 1'b0;
        last_cmd      = '0;
        tick(3);
        check("reset_command", 64'(o_command), 64'd0);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_error", 64'(o_error), 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        reset = 1'b0;
        tick(2);

        // All-zero payload with zero CRC is a good frame.
        good_or_bad_frame(P_ZERO, 8'h00, 1'b0);
        tick(3);

        // Correct CRC, then the same payload with a corrupted CRC.
        good_or_bad_frame(P_AA55, ref_crc(P_AA55), 1'b0);
        tick(3);
        good_or_bad_frame(P_AA55, ref_crc(P_AA55) ^ 8'h01, 1'b1);
        tick(3);

        // Abort after 30 bits keeps the previous command; replayed start decodes cleanly.
        start_frame();
        send_bits({8'h00, P_SEQ}, 30, 1'b0);
        exp_q.push_back('{cmd: last_cmd, err: 1'b1});
        start_frame();
        exp_q.push_back('{cmd: P_SEQ, err: 1'b0});
        last_cmd = P_SEQ;
        send_bits({ref_crc(P_SEQ), P_SEQ}, FRAME_W, 1'b1);
        tick(3);

        // Inter-bit stall longer than the timeout, then stray bits while idle.
        start_frame();
        send_bits({8'h00, P_BEEF}, 10, 1'b0);
        exp_q.push_back('{cmd: last_cmd, err: 1'b1});
        tick(BIT_TIMEOUT + 50);
        check("timeout_reported", 64'(exp_q.size()), 64'd0);
        check("timeout_not_busy", 64'(o_busy), 64'd0);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b0);
        check("idle_bits_ignored", 64'(o_busy), 64'd0);

        // Asynchronous reset at bit 40 clears everything without a strobe.
        start_frame();
        send_bits({8'h00, P_BEEF}, 40, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_command", 64'(o_command), 64'd0);
        check("midreset_error", 64'(o_error), 64'd0);
        check("midreset_valid", 64'(o_valid), 64'd0);
        check("midreset_busy", 64'(o_busy), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        good_or_bad_frame(P_BEEF, ref_crc(P_BEEF), 1'b0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        tick(2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
